// File: rtl/score_pkg.sv
// Shared types and constants for the score display: converter FSM states,
// saturation limit and the seven-segment decode table.
package score_pkg;

  localparam int BW_DEFAULT = 7;
  localparam int SAT_LIMIT  = 99;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_t;

  // Active-high segments, bit0 = a .. bit6 = g; index 0 is the rightmost entry.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    if (digit > 4'd9) seg = 7'h00;
    else              seg = SEG_TABLE[digit];
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: samples a saturated binary score and
// produces a two-digit BCD result with a one-cycle valid pulse.
module bin2bcd_seq
  import score_pkg::*;
#(
  parameter int BW = BW_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [BW-1:0] value_i,
  output logic [7:0]    bcd_o,
  output logic          valid_o
);

  localparam int          IW        = $clog2(BW + 1);
  localparam logic [IW-1:0] ITER_LAST = IW'(BW - 1);
  localparam logic [BW-1:0] SAT_VAL   = BW'(SAT_LIMIT);

  conv_state_t     state;
  logic [BW+7:0]   sreg;
  logic [BW-1:0]   last;
  logic [BW-1:0]   sat;
  logic [IW-1:0]   iter;
  logic            pending;

  function automatic logic [BW+7:0] dabble_step(input logic [BW+7:0] s);
    logic [BW+7:0] t;
    t = s;
    if (t[BW+3:BW] >= 4'd5)   t[BW+3:BW]   = t[BW+3:BW]   + 4'd3;
    if (t[BW+7:BW+4] >= 4'd5) t[BW+7:BW+4] = t[BW+7:BW+4] + 4'd3;
    return t << 1;
  endfunction

  // NOTE: combinational blocks assign every output unconditionally so no latch is inferred.
  always_comb begin
    sat = value_i;
    if (int'(value_i) > SAT_LIMIT) sat = SAT_VAL;
  end

  // Comparing the saturated value keeps an out-of-range input from retriggering forever.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      bcd_o   <= 8'h00;
      valid_o <= 1'b0;
      sreg    <= '0;
      last    <= '0;
      iter    <= '0;
      pending <= 1'b1;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (pending || (sat != last)) begin
            last    <= sat;
            sreg    <= {8'h00, sat};
            iter    <= '0;
            pending <= 1'b0;
            state   <= CONV;
          end
        end
        CONV: begin
          sreg <= dabble_step(sreg);
          iter <= iter + 1'b1;
          if (iter == ITER_LAST) state <= DONE;
        end
        DONE: begin
          bcd_o   <= sreg[BW+7:BW];
          valid_o <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/score_display.sv
// Two-digit multiplexed seven-segment score display: binary-to-BCD conversion,
// digit-scan prescaler and registered segment drive with leading-zero blanking.
module score_display
  import score_pkg::*;
#(
  parameter int BW      = BW_DEFAULT,
  parameter int MUX_DIV = 1000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [BW-1:0] value_i,
  output logic [7:0]    bcd_o,
  output logic          valid_o,
  output logic [6:0]    seg_o,
  output logic [1:0]    dig_sel_o
);

  localparam int           PW       = $clog2(MUX_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(MUX_DIV - 1);

  logic [PW-1:0] prescaler;
  logic          wrap;
  logic [1:0]    sel_next;
  logic [3:0]    digit;
  logic [6:0]    seg_next;

  bin2bcd_seq #(
    .BW (BW)
  ) u_conv (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .value_i (value_i),
    .bcd_o   (bcd_o),
    .valid_o (valid_o)
  );

  // Segments are refreshed every cycle from the digit the enable will select
  // after this edge, so a new score shows up without waiting for a scan step.
  always_comb begin
    wrap     = (prescaler == PRE_LAST);
    sel_next = wrap ? {dig_sel_o[0], dig_sel_o[1]} : dig_sel_o;
    digit    = sel_next[1] ? bcd_o[7:4] : bcd_o[3:0];
    seg_next = seg_decode(digit);
    if (sel_next[1] && (bcd_o[7:4] == 4'd0)) seg_next = 7'h00;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prescaler <= '0;
      dig_sel_o <= 2'b01;
      seg_o     <= 7'h00;
    end else begin
      prescaler <= wrap ? '0 : prescaler + 1'b1;
      dig_sel_o <= sel_next;
      seg_o     <= seg_next;
    end
  end

endmodule
